// File: rtl/scan_sequencer_if.sv
// scan_sequencer_if: bundle of run controls (enable, dwell, slot_mask) and decoder drive (a, select, slot_done, frame_done)
interface scan_sequencer_if #(parameter int DWELL_W = 8);
  logic enable;
  logic [DWELL_W-1:0] dwell;
  logic [3:0] slot_mask;
  logic [1:0] a;
  logic select;
  logic slot_done;
  logic frame_done;
  modport master(output enable, dwell, slot_mask, input a, select, slot_done, frame_done);
  modport slave(input enable, dwell, slot_mask, output a, select, slot_done, frame_done);
endinterface

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps masked slots 0..3 with blanking+dwell, driving decoder code a/select; ports clk, rst, bus (enable, dwell, slot_mask in; a, select, slot_done, frame_done out)
module scan_sequencer #(
  parameter int DWELL_W = 8,
  parameter int BLANK_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  scan_sequencer_if.slave bus
);
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLANK_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_t;
  state_t state, state_n;
  logic [1:0] slot, slot_n, nxt, nxt_n, a, a_n, low;
  logic [2:0] nx;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [DWELL_W-1:0] dcnt, dcnt_n, dwell_eff;
  logic select, select_n, slot_done, done_n, frame_done, frame_n;
  function automatic logic [1:0] code(input logic [1:0] s);
    return {~s[0], ^s};
  endfunction
  function automatic logic [1:0] lowest(input logic [3:0] m);
    logic [1:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--) if (m[i]) r = 2'(i);
    return r;
  endfunction
  function automatic logic [2:0] next_after(input logic [3:0] m, input logic [1:0] c);
    logic [2:0] r;
    logic [1:0] idx;
    r = {1'b1, c};
    for (int i = 3; i >= 1; i--) begin
      idx = c + 2'(i);
      if (m[idx]) r = {idx <= c, idx};
    end
    return r;
  endfunction
  assign low = lowest(bus.slot_mask);
  assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
  always_comb begin
    state_n = state;
    slot_n = slot;
    a_n = a;
    bcnt_n = bcnt;
    dcnt_n = dcnt;
    unique case (state)
      IDLE:
        if (bus.enable && |bus.slot_mask) begin
          state_n = BLANK;
          slot_n = low;
          a_n = code(low);
          bcnt_n = '0;
        end
      BLANK:
        if (!bus.enable) begin
          state_n = IDLE;
          slot_n = '0;
        end else if (bcnt == B_LAST) begin
          state_n = ACTIVE;
          dcnt_n = dwell_eff;
        end else bcnt_n = bcnt + BW'(1);
      ACTIVE:
        if (!bus.enable || (dcnt == DWELL_W'(1) && bus.slot_mask == '0)) begin
          state_n = IDLE;
          slot_n = '0;
        end else if (dcnt == DWELL_W'(1)) begin
          state_n = BLANK;
          slot_n = nxt;
          a_n = code(nxt);
          bcnt_n = '0;
        end else dcnt_n = dcnt - DWELL_W'(1);
      default: state_n = IDLE;
    endcase
    select_n = state_n == ACTIVE;
    done_n = select_n && dcnt_n == DWELL_W'(1);
    // successor is latched with the done pulse so frame_done always matches the slot actually taken next
    nx = next_after(bus.slot_mask, slot_n);
    frame_n = done_n && nx[2];
    nxt_n = done_n ? nx[1:0] : nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      slot <= '0;
      nxt <= '0;
      a <= 2'b10;
      select <= 1'b0;
      slot_done <= 1'b0;
      frame_done <= 1'b0;
      bcnt <= '0;
      dcnt <= '0;
    end else begin
      state <= state_n;
      slot <= slot_n;
      nxt <= nxt_n;
      a <= a_n;
      select <= select_n;
      slot_done <= done_n;
      frame_done <= frame_n;
      bcnt <= bcnt_n;
      dcnt <= dcnt_n;
    end
  end
  assign bus.a = a;
  assign bus.select = select;
  assign bus.slot_done = slot_done;
  assign bus.frame_done = frame_done;
endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Upstream driver for the 2-to-4 enable decoder. It steps a slot index through the four decoder output lines in order b[0], b[1], b[2], b[3]. Each slot is held for a programmable dwell, separated by a blanking gap, and slots can be skipped with a mask. It produces the decoder's 2-bit code `a` and its `select` enable, so exactly one decoder line is active at a time and never during a code change.

## Interface
Parameters:
- DWELL_W, 8, width of the dwell count input
- BLANK_CYCLES, 2, number of select-low cycles before each slot; legal range is 1 and up

Ports:
- clk, input, 1, single clock; all state updates on the rising edge
- rst, input, 1, synchronous active-high reset
- enable, input, 1, run request; level-sensitive
- dwell, input, DWELL_W, select-high cycles per slot; 0 is treated as 1
- slot_mask, input, 4, bit k=1 enables decoder line b[k]
- a, output, 2, decoder code (registered)
- select, output, 1, decoder enable (registered)
- slot_done, output, 1, one-cycle pulse in the final select-high cycle of a slot
- frame_done, output, 1, one-cycle pulse coincident with slot_done when the scan wraps past slot 3

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- Slot-to-code map, fixed by the decoder's line assignment:
  - slot 0 -> a=2'b10
  - slot 1 -> a=2'b01
  - slot 2 -> a=2'b11
  - slot 3 -> a=2'b00
- Reset values:
  - state=IDLE, slot=0
  - a=2'b10, select=0, slot_done=0, frame_done=0
  - counters cleared
- States: IDLE, BLANK, ACTIVE.
- IDLE:
  - select=0.
  - If enable=1 and slot_mask!=0, pick the lowest enabled slot, load `a` with its code, and go to BLANK.
- BLANK:
  - select=0; `a` holds the new code.
  - Counts BLANK_CYCLES cycles, then goes to ACTIVE.
  - `dwell` is sampled on the ACTIVE entry edge.
- ACTIVE:
  - select=1 for max(dwell,1) cycles.
  - slot_done=1 in the last of these cycles.
  - The next slot is the next enabled slot after the current one, in circular order.
  - If the search wraps (next index <= current index, including a single enabled slot), frame_done=1 in the same cycle.
  - On the following edge: go to BLANK with the new code if enable=1 and slot_mask!=0; otherwise go to IDLE.
- `a` changes only on the edge entering BLANK. It never changes while select=1.
- slot_mask and dwell changes made during a slot take effect at the next slot selection or next ACTIVE entry. Clearing the current slot's mask bit does not shorten its dwell.
- enable=0 in BLANK or ACTIVE aborts the scan:
  - next state is IDLE and select=0 on the next edge
  - no slot_done or frame_done for the aborted slot
  - `a` holds its last value
  - slot resets to 0 for the next start
- rst in any state forces the reset values on the next edge and overrides enable.

## Timing
- With enable sampled high at edge k from IDLE:
  - BLANK occupies cycles k+1 .. k+B (B=BLANK_CYCLES)
  - select is high for cycles k+B+1 .. k+B+D (D=max(dwell,1))
- Slot period is B+D cycles.
- A frame with n enabled slots lasts n*(B+D) cycles.
- slot_done and frame_done are registered and each is high for exactly one cycle.
- There is never an idle gap between slots other than the B blanking cycles.

## Test plan
- Reset: assert rst for 2 cycles with enable=1 -> a=2'b10, select=0, slot_done=0, frame_done=0; state stays IDLE until rst drops.
- Full scan (B=2, dwell=3, mask=4'b1111):
  - a sequence is 10, 01, 11, 00
  - each slot has 2 select-low cycles then 3 select-high cycles
  - slot_done fires 4 times per 20-cycle frame
  - frame_done coincides with slot 3's slot_done
  - `a` is stable whenever select=1
- Skip mask (mask=4'b0101):
  - a alternates 10, 11
  - frame_done fires with slot 2's slot_done
  - 10-cycle frame
- Single slot and zero dwell (mask=4'b1000, dwell=0):
  - a=2'b00 always
  - select high 1 cycle per 3-cycle period
  - slot_done and frame_done fire together every slot
- Abort: drop enable in the 2nd select-high cycle of slot 1 -> select=0 on the next edge, no slot_done, IDLE. Re-enable -> restarts at slot 0 (a=2'b10) after 2 blank cycles.
- Live mask/dwell change: change the mask to 4'b0010 and dwell to 5 during slot 0's ACTIVE:
  - slot 0 completes its original dwell
  - the next slot is 1 with 5 select-high cycles
  - frame_done asserts at that slot's end
